// File: rtl/elut_cfg_array_pkg.sv
// Shared types and helpers for the runtime-writable LUT array.
// State encoding is fixed (UNCFG=0, LOAD=1, DONE=2); code 3 is illegal
// and the FSM recovers from it to UNCFG.
package elut_cfg_array_pkg;

   typedef enum logic [1:0] {
      UNCFG = 2'd0,
      LOAD  = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Ceiling log2, never less than 1 so single-entry counters still get a bit.
   function automatic int clog2_min1(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

   function automatic int words_per_ch(input int k, input int cfg_w);
      return (1 << k) / cfg_w;
   endfunction

endpackage

// File: rtl/elut_cfg_lane.sv
// One LUT channel: 2**K mask bits written one CFG_W slice at a time,
// a K-bit read mux gated by done, and the registered output.
// Optional macro ELUT_CFG_READBACK_EN exposes the raw mask for readback.
module elut_cfg_lane
   import elut_cfg_array_pkg::*;
#(
   parameter  int K     = 6,
   parameter  int CFG_W = 8,
   localparam int WPC   = words_per_ch(K, CFG_W),
   localparam int SW    = clog2_min1(WPC)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [SW-1:0]    slice,
   input  logic [CFG_W-1:0] data,
   input  logic [K-1:0]     addr,
   input  logic             done,
   output logic             lut_out,
   output logic             lut_q
`ifdef ELUT_CFG_READBACK_EN
   ,
   output logic [2**K-1:0]  mask_bits
`endif
);

   logic [2**K-1:0] mask;

   // Mask storage is deliberately unreset; done gates it until fully loaded.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int s = 0; s < WPC; s++) begin
            if (slice == SW'(s)) mask[s*CFG_W +: CFG_W] <= data;
         end
      end
   end

   assign lut_out = done & mask[addr];

   // Registered copy of the gated LUT result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lut_q <= 1'b0;
      else        lut_q <= lut_out;
   end

`ifdef ELUT_CFG_READBACK_EN
   assign mask_bits = mask;
`endif

endmodule

// File: rtl/elut_cfg_array.sv
// CH-channel K-input LUT array loaded through a valid/ready word stream.
// Outputs stay 0 until every word has been accepted.
// Optional macro ELUT_CFG_READBACK_EN adds rb_addr/rb_data word readback.
//
// state | meaning
// UNCFG | no valid configuration, outputs gated off
// LOAD  | accepting configuration words, cfg_ready high
// DONE  | all words loaded, LUT outputs live
module elut_cfg_array
   import elut_cfg_array_pkg::*;
#(
   parameter  int K     = 6,
   parameter  int CH    = 4,
   parameter  int CFG_W = 8,
   localparam int WPC   = words_per_ch(K, CFG_W),
   localparam int TOTAL = CH * WPC,
   localparam int CW    = clog2_min1(TOTAL)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_start,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CFG_W-1:0]  cfg_data,
   output logic              cfg_done,
   output logic              cfg_err,
   input  logic [CH*K-1:0]   lut_in,
   output logic [CH-1:0]     lut_out,
   output logic [CH-1:0]     lut_q
`ifdef ELUT_CFG_READBACK_EN
   ,
   input  logic [CW-1:0]     rb_addr,
   output logic [CFG_W-1:0]  rb_data
`endif
);

   localparam int SW = clog2_min1(WPC);

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            accept;
   logic            last_word;
   int              ch_idx;
   logic [SW-1:0]   slice_sel;
   logic [CH-1:0]   lane_we;

   // cfg_start wins over a same-cycle handshake, so that word is dropped.
   assign accept    = (state == LOAD) & cfg_valid & ~cfg_start;
   assign last_word = (cnt == CW'(TOTAL - 1));
   assign ch_idx    = int'(cnt) / WPC;
   assign slice_sel = SW'(int'(cnt) % WPC);
   assign cfg_ready = (state == LOAD);
   assign cfg_done  = (state == DONE);

   // State and word counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= UNCFG;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state logic; the counter holds at the final word rather than wrap.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         UNCFG, DONE: begin
            if (cfg_start) begin
               state_nx = LOAD;
               cnt_nx   = '0;
            end
         end
         LOAD: begin
            if (cfg_start) begin
               cnt_nx = '0;
            end else if (accept) begin
               if (last_word) state_nx = DONE;
               else           cnt_nx   = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = UNCFG;
            cnt_nx   = '0;
         end
      endcase
   end

   // Sticky error: a word offered while not loading; cleared by a new load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              cfg_err <= 1'b0;
      else if (cfg_start)                      cfg_err <= 1'b0;
      else if (cfg_valid && (state != LOAD))   cfg_err <= 1'b1;
   end

`ifdef ELUT_CFG_READBACK_EN
   logic [2**K-1:0]  lane_mask [CH];
   logic [CFG_W-1:0] rb_word;
`endif

   for (genvar c = 0; c < CH; c++) begin : g_lane
      assign lane_we[c] = accept && (ch_idx == c);
      elut_cfg_lane #(
         .K     (K),
         .CFG_W (CFG_W)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .we        (lane_we[c]),
         .slice     (slice_sel),
         .data      (cfg_data),
         .addr      (lut_in[c*K +: K]),
         .done      (cfg_done),
         .lut_out   (lut_out[c]),
         .lut_q     (lut_q[c])
`ifdef ELUT_CFG_READBACK_EN
         ,
         .mask_bits (lane_mask[c])
`endif
      );
   end

`ifdef ELUT_CFG_READBACK_EN
   // Select the stored word addressed by rb_addr; out-of-range reads 0.
   always_comb begin
      rb_word = '0;
      for (int c = 0; c < CH; c++) begin
         for (int s = 0; s < WPC; s++) begin
            if (int'(rb_addr) == c*WPC + s) rb_word = lane_mask[c][s*CFG_W +: CFG_W];
         end
      end
   end

   // Readback is registered, one clk behind rb_addr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rb_data <= '0;
      else        rb_data <= rb_word;
   end
`endif

endmodule

// File: tb/tb_elut_cfg_array.sv
// Self-checking bench for elut_cfg_array (K=6, CH=2, CFG_W=8).
module tb_elut_cfg_array;

   localparam int K     = 6;
   localparam int CH    = 2;
   localparam int CFG_W = 8;
   localparam int WPC   = (1 << K) / CFG_W;
   localparam int TOTAL = CH * WPC;
   localparam int CW    = 4;
   localparam int LW    = CH * K;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cfg_start, cfg_valid;
   logic             cfg_ready, cfg_done, cfg_err;
   logic [CFG_W-1:0] cfg_data;
   logic [LW-1:0]    lut_in;
   logic [CH-1:0]    lut_out, lut_q;
   logic [CW-1:0]    rb_addr;
   logic [CFG_W-1:0] rb_data;

   elut_cfg_array #(.K(K), .CH(CH), .CFG_W(CFG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_data  (cfg_data),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
      .lut_in    (lut_in),
      .lut_out   (lut_out),
      .lut_q     (lut_q)
`ifdef ELUT_CFG_READBACK_EN
      ,
      .rb_addr   (rb_addr),
      .rb_data   (rb_data)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: truth tables as plain 64-bit arrays plus load status.
   logic [(1<<K)-1:0] m_mask [CH];
   bit                m_loading, m_done, m_err;
   int                m_cnt;
   logic [CH-1:0]     m_q;

   typedef struct {
      logic [LW-1:0] li;
      logic [CH-1:0] exp;
   } vec_t;
   vec_t vecs [4];

   logic [CFG_W-1:0] plan_words [TOTAL];
   logic [CFG_W-1:0] inv_words  [TOTAL];
   logic [CFG_W-1:0] rnd_words  [TOTAL];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [CH-1:0] model_out(input logic [LW-1:0] li);
      logic [CH-1:0] o;
      o = '0;
      for (int c = 0; c < CH; c++) begin
         if (m_done) o[c] = m_mask[c][li[c*K +: K]];
      end
      return o;
   endfunction

   function automatic void model_reset();
      m_loading = 0;
      m_done    = 0;
      m_err     = 0;
      m_cnt     = 0;
      m_q       = '0;
   endfunction

   // One clock: check combinational outputs, advance model, check registered.
   task automatic tick();
      logic [CH-1:0] pre;
      #1;
      pre = model_out(lut_in);
      check("lut_out", lut_out, pre);
      check("cfg_ready", cfg_ready, m_loading);
      @(posedge clk);
      if (cfg_start) begin
         m_loading = 1; m_done = 0; m_cnt = 0; m_err = 0;
      end else if (m_loading && cfg_valid) begin
         m_mask[m_cnt / WPC][(m_cnt % WPC)*CFG_W +: CFG_W] = cfg_data;
         m_cnt++;
         if (m_cnt == TOTAL) begin
            m_loading = 0; m_done = 1;
         end
      end else if (cfg_valid) begin
         m_err = 1;
      end
      m_q = pre;
      #1;
      check("lut_q", lut_q, m_q);
      check("cfg_done", cfg_done, m_done);
      check("cfg_err", cfg_err, m_err);
      @(negedge clk);
   endtask

   // Start pulse then n words with random gaps (pct = chance of valid).
   task automatic load(input logic [CFG_W-1:0] words [TOTAL], input int pct, input int n,
                       input bit hot_start);
      int sent, cyc;
      cfg_start = 1;
      cfg_valid = hot_start;
      cfg_data  = CFG_W'($urandom);
      lut_in    = LW'($urandom);
      tick();
      cfg_start = 0;
      sent = 0;
      cyc  = 0;
      while (sent < n && cyc < 2000) begin
         cfg_valid = ($urandom_range(99) < pct);
         cfg_data  = cfg_valid ? words[sent] : CFG_W'($urandom);
         lut_in    = LW'($urandom);
         tick();
         if (cfg_valid) sent++;
         cyc++;
      end
      cfg_valid = 0;
      if (cyc >= 2000) check("load_budget", 64'(sent), 64'(n));
   endtask

   task automatic sweep();
      for (int a = 0; a < (1 << K); a++) begin
         lut_in = {K'(a ^ 63), K'(a)};
         tick();
      end
   endtask

   task automatic async_reset();
      rst_n = 0;
      #1;
      model_reset();
      check("rst_lut_out", lut_out, '0);
      check("rst_lut_q", lut_q, '0);
      check("rst_ready", cfg_ready, 0);
      check("rst_done", cfg_done, 0);
      check("rst_err", cfg_err, 0);
      cfg_start = 0;
      cfg_valid = 0;
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      rst_n     = 0;
      cfg_start = 0;
      cfg_valid = 0;
      cfg_data  = '0;
      lut_in    = '0;
      rb_addr   = '0;
      model_reset();
      for (int w = 0; w < TOTAL; w++) begin
         plan_words[w] = (w < WPC) ? 8'hAA : 8'h0F;
         inv_words[w]  = ~plan_words[w];
         rnd_words[w]  = CFG_W'($urandom);
      end
      vecs[0] = '{ {6'd3, 6'd1}, 2'b11 };
      vecs[1] = '{ {6'd4, 6'd0}, 2'b00 };
      vecs[2] = '{ {6'd4, 6'd1}, 2'b01 };
      vecs[3] = '{ {6'd3, 6'd0}, 2'b10 };

      repeat (3) @(negedge clk);
      async_reset();

      // Unconfigured: outputs gated off for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         lut_in = LW'($urandom);
         tick();
      end

      // Gap-free load of the reference pattern.
      load(plan_words, 100, TOTAL, 0);
      check("done_after_last", cfg_done, 1);
      for (int i = 0; i < 4; i++) begin
         lut_in = vecs[i].li;
         #1;
         check("vec_out", lut_out, vecs[i].exp);
         tick();
         check("vec_q", lut_q, vecs[i].exp);
      end

`ifdef ELUT_CFG_READBACK_EN
      rb_addr = 4'd9;
      tick();
      check("rb_word9", rb_data, 8'h0F);
      rb_addr = 4'd3;
      tick();
      check("rb_word3", rb_data, 8'hAA);
`endif

      // Backpressure: same data with random gaps.
      load(plan_words, 40, TOTAL, 0);
      sweep();

      // Abort after six words with a dropped same-cycle word, then reload inverted.
      load(rnd_words, 100, 6, 0);
      load(inv_words, 100, TOTAL, 1);
      sweep();
      lut_in = {6'd4, 6'd0};
      tick();
      check("inv_q_live", lut_q, 2'b11);

      // Async reset while live, then mid-load, then a clean random load.
      @(posedge clk);
      #2;
      async_reset();
      load(rnd_words, 100, 10, 0);
      #2;
      async_reset();
      for (int w = 0; w < TOTAL; w++) rnd_words[w] = CFG_W'($urandom);
      load(rnd_words, 70, TOTAL, 0);
      for (int i = 0; i < 100; i++) begin
         lut_in = LW'($urandom);
         tick();
      end

      // Word offered outside LOAD sets cfg_err; cfg_start clears it.
      cfg_valid = 1;
      cfg_data  = CFG_W'($urandom);
      tick();
      check("err_in_done", cfg_err, 1);
      cfg_valid = 0;
      async_reset();
      cfg_valid = 1;
      cfg_data  = 8'hFF;
      tick();
      check("err_in_uncfg", cfg_err, 1);
      cfg_valid = 0;
      tick();
      check("err_sticky", cfg_err, 1);
      load(rnd_words, 100, TOTAL, 0);
      check("err_cleared", cfg_err, 0);
      sweep();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/elut_cfg_array.md
Name: elut_cfg_array

Overview:
- Multi-channel, runtime-writable K-input LUT array for the ZUMA overlay.
- Generalises the single 6-LUT LUTRAM wrapper to CH independent LUTs with parametrised K.
- Truth tables load through a valid/ready configuration stream, word by word.
- Each channel provides a combinational output and a registered output; outputs are gated to 0 until configuration completes.

Parameters:
- K, 6, LUT input count; 2..6.
- CH, 4, number of independent LUT channels; 1..32.
- CFG_W, 8, configuration word width; power of two, must divide 2**K.
- WORDS_PER_CH, derived localparam = 2**K / CFG_W.
- TOTAL_WORDS, derived localparam = CH * WORDS_PER_CH.

Ports:
- clk  in  1  single clock; all state is clocked on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  pulse; begin (or restart) a configuration load.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  block accepts a word this cycle.
- cfg_data  in  CFG_W  truth-table slice; bit i maps to mask bit (offset + i).
- cfg_done  out  1  all channels configured; LUT outputs live.
- cfg_err  out  1  sticky flag; a word was offered while not loading.
- lut_in  in  CH*K  channel c address = lut_in[c*K +: K].
- lut_out  out  CH  combinational LUT result per channel.
- lut_q  out  CH  lut_out registered on clk.

Behaviour:
- FSM states, shared encoding:
  - UNCFG (reset state): cfg_ready=0, cfg_done=0.
  - LOAD: cfg_ready=1.
  - DONE: cfg_ready=0, cfg_done=1.
- Transitions:
  - UNCFG/DONE + cfg_start -> LOAD; word counter cleared to 0; cfg_done drops on the next cycle.
  - LOAD + cfg_start -> LOAD; counter cleared (abort and restart). cfg_start has priority over a same-cycle handshake, so that word is dropped.
  - LOAD + handshake on word TOTAL_WORDS-1 -> DONE; cfg_done=1 from the next cycle.
- Handshake: a word is accepted when cfg_valid & cfg_ready at the rising edge.
  - Word w writes channel w / WORDS_PER_CH, mask bits [(w % WORDS_PER_CH)*CFG_W +: CFG_W].
  - Counter width = clog2(TOTAL_WORDS), minimum 1; it never wraps because the FSM leaves LOAD at the final word.
- cfg_valid outside LOAD: word ignored, cfg_err set. cfg_err clears only on reset or cfg_start.
- LUT read: lut_out[c] = cfg_done ? mask[c][lut_in_c] : 0. Zero latency from lut_in.
- lut_q[c] <= lut_out[c] every cycle. Latency is 1 clk.
- Reset (async assert, any state including mid-LOAD):
  - State = UNCFG, counter = 0.
  - cfg_ready, cfg_done, cfg_err, lut_q = 0.
  - Mask storage is not reset; its contents are undefined but unobservable, because outputs are gated by cfg_done.
- Reset deassertion: first state change no earlier than the first clk edge after rst_n rises.
- A channel's mask bits change only on its own accepted words. Partially loaded masks are never visible, because cfg_done stays 0 until the final word.

Optional Feature:
- Macro: ELUT_CFG_READBACK_EN
- With the macro defined:
  - Adds ports rb_addr (in, clog2(TOTAL_WORDS)) and rb_data (out, CFG_W).
  - rb_data is registered: it equals the stored word at rb_addr one clk after rb_addr is presented.
  - Valid in any state; reset value 0.
- Without the macro: the ports and readback logic are absent; all other behaviour is identical.

Decomposition:
- Shared include elut_cfg_defs.vh holds:
  - FSM state localparams UNCFG=2'd0, LOAD=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to UNCFG).
  - A clog2 function.
  - Derived word-count constants.
- Sub-module elut_cfg_lane: one channel.
  - Holds 2**K mask bits, the slice-write port (we, word index, data), the K-bit read mux, and the lut_q flop.
  - Instantiated CH times in a generate loop.
- The top level holds the FSM, the counter, the cfg_err flag, and the readback mux.

Test Plan:
- Reset, then lut_in arbitrary with no load -> lut_out=0, lut_q=0, cfg_ready=0, cfg_done=0 for 20 cycles.
- K=6, CH=2, CFG_W=8: cfg_start, then 16 words; channel 0 all 8'hAA, channel 1 all 8'h0F.
  - cfg_done rises 1 cycle after word 15.
  - lut_in ch0=6'd1 -> lut_out[0]=1; ch0=6'd0 -> 0.
  - ch1=6'd3 -> lut_out[1]=1; ch1=6'd4 -> 0.
  - lut_q matches lut_out one cycle later.
- Backpressure: cfg_valid toggled randomly during the load -> only handshaken words written; final masks identical to the gap-free load.
- Abort: cfg_start after word 5, then full reload with inverted data -> inverted masks everywhere; no stale words visible.
- Async reset pulse mid-LOAD (after word 9) -> outputs 0 immediately, state UNCFG; a subsequent full load succeeds.
- cfg_valid=1 in UNCFG -> cfg_err=1 and the word is ignored; cfg_start clears cfg_err.
- With ELUT_CFG_READBACK_EN: rb_addr=9 after the load above -> rb_data=8'h0F on the next cycle.
